// File: rtl/key_input_pkg.sv
// Shared constants and read-word layout for the key/switch input port.
package key_input_pkg;

    localparam int unsigned KEY_COUNT = 4;
    localparam int unsigned SW_COUNT  = 8;
    localparam int unsigned READ_W    = 16;

    localparam int unsigned SW_LSB    = 0;
    localparam int unsigned LEVEL_LSB = 8;
    localparam int unsigned EDGE_LSB  = 12;

    typedef struct packed {
        logic [KEY_COUNT-1:0] edge_capture;
        logic [KEY_COUNT-1:0] key_level;
        logic [SW_COUNT-1:0]  switch_sync;
    } read_word_t;

    // Flatten the read word onto the bus using the documented field offsets.
    function automatic logic [READ_W-1:0] pack_read_word(input read_word_t w);
        logic [READ_W-1:0] v;
        v = '0;
        v[SW_LSB    +: SW_COUNT]  = w.switch_sync;
        v[LEVEL_LSB +: KEY_COUNT] = w.key_level;
        v[EDGE_LSB  +: KEY_COUNT] = w.edge_capture;
        return v;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-key debouncer: accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
// With KEY_INPUT_RELEASE_EDGE_EN defined it also emits a release (fall) pulse.
module key_debouncer
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic synced,
    output logic stable,
    output logic rise
`ifdef KEY_INPUT_RELEASE_EDGE_EN
    ,
    output logic fall
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (synced != stable) && (cnt == CNT_LAST);

    // Any sample agreeing with the stable level restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            rise <= accept & synced;
            if (synced == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef KEY_INPUT_RELEASE_EDGE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fall <= 1'b0;
        end else begin
            fall <= accept & ~synced;
        end
    end
`endif

endmodule

// File: rtl/key_input_port.sv
// Memory-mapped pushbutton/switch input port with debounced, read-cleared key edge capture.
// Define KEY_INPUT_RELEASE_EDGE_EN to capture release edges as well as presses.
module key_input_port
    import key_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [KEY_COUNT-1:0] key_n,
    input  logic [SW_COUNT-1:0]  switches,
    input  logic                 read_enable,
    output logic [READ_W-1:0]    read_data,
    output logic                 read_valid,
    output logic                 key_pressed
);

    logic [KEY_COUNT-1:0] key_meta;
    logic [KEY_COUNT-1:0] key_sync;
    logic [KEY_COUNT-1:0] key_synced;
    logic [KEY_COUNT-1:0] key_level;
    logic [KEY_COUNT-1:0] key_rise;
    logic [KEY_COUNT-1:0] edge_set;
    logic [KEY_COUNT-1:0] edge_capture;
    logic [KEY_COUNT-1:0] edge_next;
    logic [SW_COUNT-1:0]  sw_meta;
    logic [SW_COUNT-1:0]  switch_sync;
    read_word_t           snapshot;

`ifdef KEY_INPUT_RELEASE_EDGE_EN
    logic [KEY_COUNT-1:0] key_fall;
`endif

    // Two-flop synchronisers; keys reset to the released (high) state so reset never fakes a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_meta    <= '1;
            key_sync    <= '1;
            sw_meta     <= '0;
            switch_sync <= '0;
        end else begin
            key_meta    <= key_n;
            key_sync    <= key_meta;
            sw_meta     <= switches;
            switch_sync <= sw_meta;
        end
    end

    assign key_synced = ~key_sync;

    for (genvar i = 0; i < int'(KEY_COUNT); i++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock  (clock),
            .reset  (reset),
            .synced (key_synced[i]),
            .stable (key_level[i]),
            .rise   (key_rise[i])
`ifdef KEY_INPUT_RELEASE_EDGE_EN
            ,
            .fall   (key_fall[i])
`endif
        );
    end

`ifdef KEY_INPUT_RELEASE_EDGE_EN
    assign edge_set = key_rise | key_fall;
`else
    assign edge_set = key_rise;
`endif

    // Read clears only the bits it reported; an edge landing in the read cycle survives.
    always_comb begin
        snapshot.edge_capture = edge_capture;
        snapshot.key_level    = key_level;
        snapshot.switch_sync  = switch_sync;
        edge_next = edge_capture | edge_set;
        if (read_enable) begin
            edge_next = (edge_capture & ~snapshot.edge_capture) | edge_set;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            edge_capture <= '0;
            key_pressed  <= 1'b0;
            read_data    <= '0;
            read_valid   <= 1'b0;
        end else begin
            edge_capture <= edge_next;
            key_pressed  <= |edge_next;
            read_valid   <= read_enable;
            if (read_enable) begin
                read_data <= pack_read_word(snapshot);
            end
        end
    end

endmodule
